// File: rtl/exec_mul_pkg.sv
// Shared types and sizing helpers for the execute-stage iterative multiplier.
package exec_mul_pkg;

  localparam int MUL_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

  function automatic int mul_iters(input int bits_per_cycle);
    return MUL_W / bits_per_cycle;
  endfunction

endpackage

// File: rtl/exec_mul_step.sv
// One shift-add iteration: adds multiplicand x multiplier slice into the accumulator
// at the bit offset selected by the iteration count, and retires that slice.
module exec_mul_step
  import exec_mul_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int CNT_W = 5
) (
  input  logic [2*MUL_W-1:0] acc,
  input  logic [MUL_W-1:0]   mcand,
  input  logic [MUL_W-1:0]   mplier,
  input  logic [CNT_W-1:0]   cnt,
  output logic [2*MUL_W-1:0] acc_next,
  output logic [MUL_W-1:0]   mplier_next
);

  localparam int SH = $clog2(BITS_PER_CYCLE);

  logic [BITS_PER_CYCLE-1:0] slice;
  logic [2*MUL_W-1:0]        partial;
  logic [5:0]                shamt;

  assign slice   = mplier[BITS_PER_CYCLE-1:0];
  assign partial = {{MUL_W{1'b0}}, mcand} * {{(2*MUL_W-BITS_PER_CYCLE){1'b0}}, slice};
  // Offset is cnt * BITS_PER_CYCLE; widened first so radix-4 counts cannot truncate.
  assign shamt   = 6'(cnt) << SH;

  assign acc_next    = acc + (partial << shamt);
  assign mplier_next = mplier >> BITS_PER_CYCLE;

endmodule

// File: rtl/exec_mul_sequencer.sv
// Iterative 32x32 multiply sequencer for the execute stage: load, shift-add, sign fix.
// Optional EXEC_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier is zero.
module exec_mul_sequencer
  import exec_mul_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             mul_req,
  input  logic             mul_signed,
  input  logic             mul_hi,
  input  logic [MUL_W-1:0] mul_rs_val,
  input  logic [MUL_W-1:0] mul_rt_val,
  input  logic             mul_kill,
  output logic             mul_stall,
  output logic             mul_done,
  output logic [MUL_W-1:0] mul_result,
  output logic             mul_busy
);

  localparam int ITERS = mul_iters(BITS_PER_CYCLE);
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  mul_state_t         state;
  logic [2*MUL_W-1:0] acc;
  logic [2*MUL_W-1:0] acc_step;
  logic [2*MUL_W-1:0] acc_fin;
  logic [2*MUL_W-1:0] prod;
  logic [MUL_W-1:0]   mcand;
  logic [MUL_W-1:0]   mplier;
  logic [MUL_W-1:0]   mplier_step;
  logic [MUL_W-1:0]   rs_mag;
  logic [MUL_W-1:0]   rt_mag;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic               hi;
  logic               last;
  logic               skip;

  // Negating 0x80000000 wraps back to 0x80000000, which is the correct unsigned magnitude.
  assign rs_mag = (mul_signed && mul_rs_val[MUL_W-1]) ? (~mul_rs_val + 1'b1) : mul_rs_val;
  assign rt_mag = (mul_signed && mul_rt_val[MUL_W-1]) ? (~mul_rt_val + 1'b1) : mul_rt_val;

  exec_mul_step #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE),
    .CNT_W         (CNT_W)
  ) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .cnt        (cnt),
    .acc_next   (acc_step),
    .mplier_next(mplier_step)
  );

  assign last = (cnt == CNT_W'(ITERS - 1));

`ifdef EXEC_MUL_EARLY_EXIT_EN
  assign skip = (mplier == '0);
`else
  assign skip = 1'b0;
`endif

  assign acc_fin   = skip ? acc : acc_step;
  assign prod      = neg ? (~acc_fin + 64'd1) : acc_fin;
  assign mul_stall = mul_req && (state != DONE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
      hi         <= 1'b0;
      mul_done   <= 1'b0;
      mul_result <= '0;
      mul_busy   <= 1'b0;
    end else if (mul_kill) begin
      state    <= IDLE;
      mul_done <= 1'b0;
      mul_busy <= 1'b0;
    end else begin
      mul_done <= 1'b0;
      case (state)
        IDLE: begin
          if (mul_req) begin
            mcand    <= rs_mag;
            mplier   <= rt_mag;
            neg      <= mul_signed & (mul_rs_val[MUL_W-1] ^ mul_rt_val[MUL_W-1]);
            hi       <= mul_hi;
            acc      <= '0;
            cnt      <= '0;
            state    <= RUN;
            mul_busy <= 1'b1;
          end
        end
        RUN: begin
          acc    <= acc_fin;
          mplier <= mplier_step;
          cnt    <= cnt + 1'b1;
          if (skip || last) begin
            state      <= DONE;
            mul_done   <= 1'b1;
            mul_result <= hi ? prod[2*MUL_W-1:MUL_W] : prod[MUL_W-1:0];
          end
        end
        DONE: begin
          state    <= IDLE;
          mul_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          mul_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_mul_sequencer.sv
// Directed bench for exec_mul_sequencer: vector table plus kill, back-to-back and reset sequences.
module tb_exec_mul_sequencer;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        h;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 17;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        mul_req;
  logic        mul_signed;
  logic        mul_hi;
  logic [31:0] mul_rs_val;
  logic [31:0] mul_rt_val;
  logic        mul_kill;
  logic        mul_stall;
  logic        mul_done;
  logic [31:0] mul_result;
  logic        mul_busy;

  int errors = 0;
  int checks = 0;
  int done_pulses = 0;

  vec_t vecs [NVEC];

  exec_mul_sequencer dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .mul_req   (mul_req),
    .mul_signed(mul_signed),
    .mul_hi    (mul_hi),
    .mul_rs_val(mul_rs_val),
    .mul_rt_val(mul_rt_val),
    .mul_kill  (mul_kill),
    .mul_stall (mul_stall),
    .mul_done  (mul_done),
    .mul_result(mul_result),
    .mul_busy  (mul_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) if (mul_done) done_pulses++;

  // Stimulus protocol guard: mul_req must stay high through RUN unless the op is killed.
  always @(posedge i_clk) begin
    if (!i_reset && mul_busy && !mul_done && !mul_req && !mul_kill) begin
      errors++;
      $display("FAIL req_drop: mul_req got 0 during RUN, required 1");
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Expected cycle (from the load cycle) at which mul_done is seen.
  function automatic int exp_lat(input logic [31:0] b, input logic s);
`ifdef EXEC_MUL_EARLY_EXIT_EN
    logic [31:0] m;
    int runs;
    m = (s && b[31]) ? (~b + 32'd1) : b;
    runs = 0;
    while (m != 0) begin
      m = m >> 1;
      runs++;
    end
    return (runs == 32) ? 33 : 2 + runs;
`else
    return 33;
`endif
  endfunction

  task automatic do_mul(input vec_t v, input int idx);
    int cyc;
    int stalls;
    bit got;
    logic busy1;
    int lat;
    lat = exp_lat(v.b, v.s);
    mul_rs_val = v.a;
    mul_rt_val = v.b;
    mul_signed = v.s;
    mul_hi     = v.h;
    mul_req    = 1'b1;
    #1;
    cyc = 0;
    stalls = 0;
    got = 0;
    busy1 = 1'b0;
    while (!got && cyc <= 100) begin
      if (cyc == 1) busy1 = mul_busy;
      if (mul_done) got = 1;
      else begin
        if (mul_stall) stalls++;
        tick();
        cyc++;
      end
    end
    check($sformatf("v%0d_done_seen", idx), 64'(got), 64'd1);
    check($sformatf("v%0d_latency", idx), 64'(cyc), 64'(lat));
    check($sformatf("v%0d_result", idx), 64'(mul_result), 64'(v.exp));
    check($sformatf("v%0d_stall_cycles", idx), 64'(stalls), 64'(lat));
    check($sformatf("v%0d_stall_done", idx), 64'(mul_stall), 64'd0);
    check($sformatf("v%0d_busy_run", idx), 64'(busy1), 64'd1);
    mul_req = 1'b0;
    tick();
    check($sformatf("v%0d_done_single", idx), 64'(mul_done), 64'd0);
    check($sformatf("v%0d_idle_after", idx), 64'(mul_busy), 64'd0);
    check($sformatf("v%0d_result_hold", idx), 64'(mul_result), 64'(v.exp));
  endtask

  initial begin
    int cyc;
    int first;
    int second;
    int pulses_before;
    vec_t v;

    vecs[0]  = '{32'd7,        32'd6,        1'b0, 1'b0, 32'h0000002A};
    vecs[1]  = '{32'hFFFFFFFD, 32'd5,        1'b1, 1'b0, 32'hFFFFFFF1};
    vecs[2]  = '{32'hFFFFFFFD, 32'd5,        1'b1, 1'b1, 32'hFFFFFFFF};
    vecs[3]  = '{32'hFFFFFFFD, 32'd5,        1'b0, 1'b1, 32'h00000004};
    vecs[4]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h40000000};
    vecs[5]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h00000000};
    vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFE};
    vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000001};
    vecs[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000};
    vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000001};
    vecs[10] = '{32'd7,        32'hFFFFFFFA, 1'b1, 1'b1, 32'hFFFFFFFF};
    vecs[11] = '{32'd7,        32'hFFFFFFFA, 1'b1, 1'b0, 32'hFFFFFFD6};
    vecs[12] = '{32'd12345,    32'd0,        1'b0, 1'b0, 32'h00000000};
    vecs[13] = '{32'd5,        32'd1,        1'b0, 1'b0, 32'h00000005};
    vecs[14] = '{32'h00010000, 32'h00010000, 1'b0, 1'b1, 32'h00000001};
    vecs[15] = '{32'h7FFFFFFF, 32'd2,        1'b1, 1'b0, 32'hFFFFFFFE};
    vecs[16] = '{32'h80000000, 32'd1,        1'b1, 1'b1, 32'hFFFFFFFF};

    i_reset = 1'b1;
    mul_req = 1'b0;
    mul_signed = 1'b0;
    mul_hi = 1'b0;
    mul_rs_val = '0;
    mul_rt_val = '0;
    mul_kill = 1'b0;
    repeat (3) tick();
    check("rst_done", 64'(mul_done), 64'd0);
    check("rst_busy", 64'(mul_busy), 64'd0);
    check("rst_result", 64'(mul_result), 64'd0);
    check("rst_stall", 64'(mul_stall), 64'd0);
    i_reset = 1'b0;
    tick();

    for (int i = 0; i < NVEC; i++) do_mul(vecs[i], i);

    // Kill while IDLE must suppress the load.
    mul_rs_val = 32'd9;
    mul_rt_val = 32'd9;
    mul_signed = 1'b0;
    mul_hi = 1'b0;
    mul_req = 1'b1;
    mul_kill = 1'b1;
    repeat (3) tick();
    check("kill_idle_busy", 64'(mul_busy), 64'd0);
    mul_req = 1'b0;
    mul_kill = 1'b0;
    tick();

    // Kill during RUN cycle 10: back in IDLE at cycle 11, result untouched, no done.
    pulses_before = done_pulses;
    mul_rs_val = 32'd7;
    mul_rt_val = 32'hFFFFFFFF;
    mul_req = 1'b1;
    repeat (10) tick();
    check("kill_busy_before", 64'(mul_busy), 64'd1);
    mul_kill = 1'b1;
    tick();
    check("kill_busy_after", 64'(mul_busy), 64'd0);
    check("kill_done", 64'(mul_done), 64'd0);
    check("kill_result_kept", 64'(mul_result), 64'hFFFFFFFF);
    mul_req = 1'b0;
    mul_kill = 1'b0;
    repeat (40) tick();
    check("kill_no_done", 64'(done_pulses), 64'(pulses_before));
    v = '{32'd2, 32'd3, 1'b0, 1'b0, 32'd6};
    do_mul(v, 100);

    // Back-to-back with mul_req held: operands switch in the DONE cycle.
    mul_rs_val = 32'd2;
    mul_rt_val = 32'd3;
    mul_signed = 1'b0;
    mul_hi = 1'b0;
    mul_req = 1'b1;
    #1;
    cyc = 0;
    first = -1;
    second = -1;
    while (second < 0 && cyc < 200) begin
      if (mul_done) begin
        if (first < 0) begin
          first = cyc;
          check("b2b_result_a", 64'(mul_result), 64'd6);
          check("b2b_stall_a", 64'(mul_stall), 64'd0);
          mul_rs_val = 32'd4;
          mul_rt_val = 32'd5;
        end else begin
          second = cyc;
          check("b2b_result_b", 64'(mul_result), 64'd20);
        end
      end
      if (second < 0) begin
        tick();
        cyc++;
      end
    end
    check("b2b_first_lat", 64'(first), 64'(exp_lat(32'd3, 1'b0)));
    check("b2b_gap", 64'(second - first), 64'(1 + exp_lat(32'd5, 1'b0)));
    mul_req = 1'b0;
    tick();

    // Reset in the middle of RUN clears every registered output.
    mul_rs_val = 32'd9;
    mul_rt_val = 32'hFFFFFFFF;
    mul_req = 1'b1;
    repeat (5) tick();
    check("rst_mid_busy_before", 64'(mul_busy), 64'd1);
    i_reset = 1'b1;
    tick();
    check("rst_mid_busy", 64'(mul_busy), 64'd0);
    check("rst_mid_done", 64'(mul_done), 64'd0);
    check("rst_mid_result", 64'(mul_result), 64'd0);
    mul_req = 1'b0;
    i_reset = 1'b0;
    tick();
    v = '{32'd3, 32'd3, 1'b0, 1'b0, 32'd9};
    do_mul(v, 101);

    check("done_pulse_total", 64'(done_pulses), 64'(NVEC + 4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_mul_sequencer.md
Name: exec_mul_sequencer

Overview:
- Controller for a shared iterative 32x32 multiplier used by the execute stage for MUL/MULH-class ALU ops.
- Sequences operand load, shift-add iterations and sign correction.
- Drives a stall toward the execute stage until the product is ready, then presents a registered 32-bit result (low or high half) for one consume cycle.
- Sits beside the execute-stage ALU. Its stall is OR-ed into the execute-stage stall and its result is muxed into the ALU result.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle; legal values 1, 2, 4.
- ITERS, 32/BITS_PER_CYCLE, derived; number of RUN cycles without early exit.

Ports:
- i_clk  input  1  clock
- i_reset  input  1  synchronous active-high reset
- mul_req  input  1  execute stage holds a multiply op; operands stable while mul_stall=1
- mul_signed  input  1  1 = treat operands as two's complement
- mul_hi  input  1  1 = return product[63:32], 0 = product[31:0]
- mul_rs_val  input  32  multiplicand
- mul_rt_val  input  32  multiplier
- mul_kill  input  1  abort the in-flight op (pipeline flush/redirect)
- mul_stall  output  1  combinational; hold the execute stage
- mul_done  output  1  registered; one-cycle pulse, result valid and consumed this cycle
- mul_result  output  32  registered product half
- mul_busy  output  1  registered; state != IDLE

Behaviour:
- Reset: state=IDLE; mul_done=0, mul_result=0, mul_busy=0; internal accumulator, multiplicand, multiplier and counter cleared. Reset mid-operation abandons the op with no mul_done.
- States and transitions:
  - IDLE: if mul_req && !mul_kill, load |rs| and |rt| (magnitudes when mul_signed, else raw), latch neg = mul_signed & (rs[31]^rt[31]) and hi, clear acc and cnt, then go to RUN.
  - RUN: add multiplicand x multiplier[BITS_PER_CYCLE-1:0] into the 64-bit acc at offset cnt*BITS_PER_CYCLE; shift the multiplier right by BITS_PER_CYCLE; cnt++. When cnt==ITERS-1, go to DONE.
  - DONE (entered from RUN): mul_result = hi ? p[63:32] : p[31:0], where p = neg ? -acc : acc (64-bit two's complement). Registered on entry; mul_done=1 for exactly one cycle; next state IDLE.
- mul_stall = mul_req && (state != DONE). It is asserted in the load cycle and all RUN cycles, and deasserted in the DONE cycle so the pipeline advances.
- Latency from mul_req rising in IDLE: stall cycles = 1 + ITERS; mul_done at cycle 1+ITERS. For BITS_PER_CYCLE=1, mul_done is at cycle 33.
- Back-to-back multiplies: the DONE cycle consumes op A. The next cycle, IDLE sees op B's mul_req and loads it. There is no bubble beyond the IDLE load cycle.
- mul_kill: highest priority after reset. In any state it forces IDLE next cycle with mul_done=0. mul_result keeps its previous value. In IDLE, kill suppresses the load.
- mul_req dropping mid-RUN without kill is illegal; behaviour is unspecified, and verification must assert against it.
- mul_result holds its value until the next DONE entry.
- Width rules:
  - Magnitude of 0x80000000 is 0x80000000, computed unsigned in 33 bits.
  - acc is 64 bits with no overflow possible.
  - cnt is $clog2(ITERS) bits.

Optional Feature:
- Macro: EXEC_MUL_EARLY_EXIT_EN.
- Defined: in RUN, if the remaining multiplier register == 0 at the start of a cycle, skip the accumulate and go to DONE next cycle. Multiply by 0 or small rt completes early; x*0 gives mul_done at cycle 2.
- Undefined: RUN always lasts exactly ITERS cycles. Latency is fixed and data-independent.

Decomposition:
- Package exec_mul_pkg:
  - state enum mul_state_t {IDLE, RUN, DONE}
  - localparam MUL_W=32
  - function computing ITERS from BITS_PER_CYCLE
- Sub-module exec_mul_step: combinational single iteration. Inputs are acc, multiplicand, multiplier slice and cnt; outputs are next acc and next multiplier. This isolates the radix so BITS_PER_CYCLE variants share the sequencer FSM.

Test Plan:
- Unsigned 7x6, lo, BITS_PER_CYCLE=1 -> mul_stall high cycles 0..32, mul_done at cycle 33, mul_result=0x0000002A.
- Signed -3x5 -> lo=0xFFFFFFF1 and hi=0xFFFFFFFF; signed 0x80000000x0x80000000 hi -> 0x40000000.
- Unsigned 0xFFFFFFFFx0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; signed same operands hi -> 0x00000000, lo -> 0x00000001.
- Kill asserted at cycle 10 of RUN -> IDLE at cycle 11, no mul_done, mul_result unchanged. A following request 2x3 completes with result 6.
- Back-to-back 2x3 then 4x5 with mul_req held -> two mul_done pulses 34 cycles apart, results 6 then 20; reset asserted mid-RUN -> all outputs 0 next cycle.
- With EXEC_MUL_EARLY_EXIT_EN: 12345x0 -> mul_done at cycle 2, result 0; 5x1 -> mul_done at cycle 3, result 5. Without the macro both complete at cycle 33.
